// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply (or single-cycle when
// FAST_MUL=1) and restoring divide, holding the pipeline until a one-cycle write-back.
module exu_muldiv #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idex2mdu_valid_i,
    input  logic [2:0]        idex2mdu_funct3_i,
    input  logic [XLEN-1:0]   idex2mdu_source1_i,
    input  logic [XLEN-1:0]   idex2mdu_source2_i,
    input  logic [REG_AW-1:0] idex2mdu_rd_addr_i,
    input  logic              cu2mdu_flush_i,
    output logic              mdu2cu_stall_o,
    output logic              mdu2regs_wb_en_o,
    output logic [REG_AW-1:0] mdu2regs_rd_addr_o,
    output logic [XLEN-1:0]   mdu2regs_rd_data_o,
    output logic              mdu_busy_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_funct3;
    logic [REG_AW-1:0] r_rd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_rd_data;

    logic              w_accept;
    logic              w_s1_signed;
    logic              w_s2_signed;
    logic              w_neg1;
    logic              w_neg2;
    logic              w_is_div;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN-1:0]   w_special;
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_step_acc;
    logic              w_load_out;
    logic [XLEN-1:0]   w_out_data;
    logic [REG_AW-1:0] w_out_rd;

    // Applies the recorded signs to a magnitude result and picks the requested half/part.
    // For multiplies the whole accumulator is the product; for divides it is {rem, quo}.
    function automatic logic [XLEN-1:0] fix_select(input logic [2:0]        f3,
                                                    input logic [2*XLEN-1:0] acc,
                                                    input logic              neg_q,
                                                    input logic              neg_r);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            3'b000:                 res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res = quo;
            default:                res = rem;
        endcase
        return res;
    endfunction

    // Operand decode at accept: signedness, magnitudes, special-case division results.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && idex2mdu_valid_i && !cu2mdu_flush_i;
        w_is_div    = idex2mdu_funct3_i[2];
        w_s1_signed = (idex2mdu_funct3_i == 3'b001) || (idex2mdu_funct3_i == 3'b010) ||
                      (idex2mdu_funct3_i == 3'b100) || (idex2mdu_funct3_i == 3'b110);
        w_s2_signed = (idex2mdu_funct3_i == 3'b001) || (idex2mdu_funct3_i == 3'b100) ||
                      (idex2mdu_funct3_i == 3'b110);
        w_neg1      = w_s1_signed && idex2mdu_source1_i[XLEN-1];
        w_neg2      = w_s2_signed && idex2mdu_source2_i[XLEN-1];
        w_mag1      = w_neg1 ? -idex2mdu_source1_i : idex2mdu_source1_i;
        w_mag2      = w_neg2 ? -idex2mdu_source2_i : idex2mdu_source2_i;
        w_div0      = (idex2mdu_source2_i == {XLEN{1'b0}});
        w_ovf       = ((idex2mdu_funct3_i == 3'b100) || (idex2mdu_funct3_i == 3'b110)) &&
                      (idex2mdu_source1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (idex2mdu_source2_i == {XLEN{1'b1}});
        if (w_div0) begin
            w_special = idex2mdu_funct3_i[1] ? idex2mdu_source1_i : {XLEN{1'b1}};
        end else begin
            w_special = idex2mdu_funct3_i[1] ? {XLEN{1'b0}} : idex2mdu_source1_i;
        end
        w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        if (r_state == S_DIV) begin
            if (!w_div_diff[XLEN]) begin
                w_step_acc = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_step_acc = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end else begin
            w_step_acc = {w_mul_sum, r_acc[XLEN-1:1]};
        end
    end

    // Next-state logic and the result to capture when DONE is entered.
    always_comb begin
        w_next_state = r_state;
        w_load_out   = 1'b0;
        w_out_data   = fix_select(r_funct3, w_step_acc, r_neg_q, r_neg_r);
        w_out_rd     = r_rd;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_rd = idex2mdu_rd_addr_i;
                    if (w_is_div) begin
                        if (w_div0 || w_ovf) begin
                            w_next_state = S_DONE;
                            w_load_out   = 1'b1;
                            w_out_data   = w_special;
                        end else begin
                            w_next_state = S_DIV;
                        end
                    end else if (FAST_MUL) begin
                        w_next_state = S_DONE;
                        w_load_out   = 1'b1;
                        w_out_data   = fix_select(idex2mdu_funct3_i, w_fast_prod,
                                                  w_neg1 ^ w_neg2, w_neg1);
                    end else begin
                        w_next_state = S_MUL;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (cu2mdu_flush_i) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_next_state = S_DONE;
                    w_load_out   = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, operand latches, iteration datapath and write-back registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_funct3  <= 3'b000;
            r_rd      <= {REG_AW{1'b0}};
            r_acc     <= {(2*XLEN){1'b0}};
            r_opb     <= {XLEN{1'b0}};
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rd_addr <= {REG_AW{1'b0}};
            r_rd_data <= {XLEN{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_funct3 <= idex2mdu_funct3_i;
                r_rd     <= idex2mdu_rd_addr_i;
                r_neg_q  <= w_neg1 ^ w_neg2;
                r_neg_r  <= w_neg1;
                r_cnt    <= CW'(XLEN);
                r_opb    <= w_is_div ? w_mag2 : w_mag1;
                r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_load_out) begin
                r_rd_addr <= w_out_rd;
                r_rd_data <= w_out_data;
            end else begin
                r_rd_addr <= r_rd_addr;
            end
        end
    end

    assign mdu2cu_stall_o     = !rst && (((r_state == S_IDLE) && idex2mdu_valid_i && !cu2mdu_flush_i) ||
                                         (r_state == S_MUL) || (r_state == S_DIV));
    assign mdu2regs_wb_en_o   = (r_state == S_DONE) && !cu2mdu_flush_i;
    assign mdu2regs_rd_addr_o = r_rd_addr;
    assign mdu2regs_rd_data_o = r_rd_data;
    assign mdu_busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_exu_muldiv.sv
// Self-checking bench for exu_muldiv: directed table, flush/reset sequences and
// randomized operations checked against a plain-arithmetic RV32M model.
module tb_exu_muldiv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        valid_f = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic        flush = 1'b0;

    logic        stall_s, wb_s, busy_s;
    logic [4:0]  rd_s;
    logic [31:0] data_s;
    logic        stall_f, wb_f, busy_f;
    logic [4:0]  rd_f;
    logic [31:0] data_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exu_muldiv #(.XLEN(32), .REG_AW(5), .FAST_MUL(1'b0)) dut (
        .clk(clk), .rst(rst),
        .idex2mdu_valid_i(valid), .idex2mdu_funct3_i(funct3),
        .idex2mdu_source1_i(src1), .idex2mdu_source2_i(src2),
        .idex2mdu_rd_addr_i(rd_addr), .cu2mdu_flush_i(flush),
        .mdu2cu_stall_o(stall_s), .mdu2regs_wb_en_o(wb_s),
        .mdu2regs_rd_addr_o(rd_s), .mdu2regs_rd_data_o(data_s),
        .mdu_busy_o(busy_s)
    );

    exu_muldiv #(.XLEN(32), .REG_AW(5), .FAST_MUL(1'b1)) dut_f (
        .clk(clk), .rst(rst),
        .idex2mdu_valid_i(valid_f), .idex2mdu_funct3_i(funct3),
        .idex2mdu_source1_i(src1), .idex2mdu_source2_i(src2),
        .idex2mdu_rd_addr_i(rd_addr), .cu2mdu_flush_i(flush),
        .mdu2cu_stall_o(stall_f), .mdu2regs_wb_en_o(wb_f),
        .mdu2regs_rd_addr_o(rd_f), .mdu2regs_rd_data_o(data_f),
        .mdu_busy_o(busy_f)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          fast;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // RV32M result computed with 64-bit host arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, input bit fast);
        bit special;
        special = (b == 32'd0) ||
                  ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
        if (f3[2]) return special ? 1 : 33;
        return fast ? 1 : 33;
    endfunction

    // Issue one operation (caller is just after a rising edge with the unit idle).
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit fast,
                          input logic [31:0] exp_data, input int exp_lat);
        int          first;
        int          pulses;
        logic [31:0] got_data;
        logic [4:0]  got_rd;
        bit          stall_bad;
        first = -1; pulses = 0; got_data = 32'd0; got_rd = 5'd0; stall_bad = 1'b0;
        funct3 = f3; src1 = a; src2 = b; rd_addr = rd;
        if (fast) valid_f = 1'b1; else valid = 1'b1;
        #1;
        check($sformatf("%s.stall_T", tag), fast ? stall_f : stall_s, 1'b1);
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(posedge clk); #1;
            if ((fast ? wb_f : wb_s) === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first    = k;
                    got_data = fast ? data_f : data_s;
                    got_rd   = fast ? rd_f : rd_s;
                end
            end
            if (k < exp_lat && (fast ? stall_f : stall_s) !== 1'b1) stall_bad = 1'b1;
            if (k >= exp_lat && (fast ? stall_f : stall_s) !== 1'b0) stall_bad = 1'b1;
            if (k == exp_lat) begin valid = 1'b0; valid_f = 1'b0; end
        end
        check($sformatf("%s.latency", tag), first, exp_lat);
        check($sformatf("%s.pulses", tag), pulses, 1);
        check($sformatf("%s.data", tag), got_data, exp_data);
        check($sformatf("%s.rd", tag), got_rd, rd);
        check($sformatf("%s.hold", tag), fast ? data_f : data_s, exp_data);
        check($sformatf("%s.stall_window", tag), stall_bad, 1'b0);
    endtask

    initial begin
        int pulses;
        vecs.push_back(vec_t'{3'd0, 32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 33});
        vecs.push_back(vec_t'{3'd1, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 33});
        vecs.push_back(vec_t'{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 33});
        vecs.push_back(vec_t'{3'd2, 32'hFFFFFFFF, 32'd2,        1'b0, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{3'd4, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 33});
        vecs.push_back(vec_t'{3'd6, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 33});
        vecs.push_back(vec_t'{3'd5, 32'd100,      32'd7,        1'b0, 32'd14,       33});
        vecs.push_back(vec_t'{3'd7, 32'd100,      32'd7,        1'b0, 32'd2,        33});
        vecs.push_back(vec_t'{3'd4, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 1});
        vecs.push_back(vec_t'{3'd6, 32'd5,        32'd0,        1'b0, 32'd5,        1});
        vecs.push_back(vec_t'{3'd5, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 1});
        vecs.push_back(vec_t'{3'd7, 32'd5,        32'd0,        1'b0, 32'd5,        1});
        vecs.push_back(vec_t'{3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1});
        vecs.push_back(vec_t'{3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        1});
        vecs.push_back(vec_t'{3'd0, 32'h00010000, 32'h00010000, 1'b1, 32'd0,        1});
        vecs.push_back(vec_t'{3'd3, 32'h00010000, 32'h00010000, 1'b1, 32'd1,        1});
        vecs.push_back(vec_t'{3'd1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 1});
        vecs.push_back(vec_t'{3'd2, 32'hFFFFFFFF, 32'd2,        1'b1, 32'hFFFFFFFF, 1});

        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", {stall_s, stall_f}, 2'b00);
        check("reset.wb_en", {wb_s, wb_f}, 2'b00);
        check("reset.rd", {rd_s, rd_f}, 10'd0);
        check("reset.data", {data_s, data_f}, 64'd0);
        check("reset.busy", {busy_s, busy_f}, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i),
                   vecs[i].fast, vecs[i].exp_data, vecs[i].exp_lat);
        end

        // Flush mid-divide, then an immediate new accept.
        pulses = 0;
        funct3 = 3'd5; src1 = 32'd1000; src2 = 32'd3; rd_addr = 5'd9; valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (wb_s === 1'b1) pulses++;
        end
        flush = 1'b1;
        #1;
        if (wb_s === 1'b1) pulses++;
        @(posedge clk); #1;
        flush = 1'b0;
        if (wb_s === 1'b1) pulses++;
        check("flush.busy", busy_s, 1'b0);
        check("flush.no_pulse", pulses, 0);
        run_op("flush.next", 3'd4, 32'hFFFFFF9C, 32'd7, 5'd10, 1'b0, 32'hFFFFFFF2, 33);

        // Asynchronous reset in the middle of a multiply.
        funct3 = 3'd0; src1 = 32'd123; src2 = 32'd456; rd_addr = 5'd3; valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; valid = 1'b0;
        #1;
        check("rst_mid.stall", stall_s, 1'b0);
        check("rst_mid.wb_en", wb_s, 1'b0);
        check("rst_mid.rd", rd_s, 5'd0);
        check("rst_mid.data", data_s, 32'd0);
        check("rst_mid.busy", busy_s, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (wb_s === 1'b1) pulses++;
        end
        check("rst_mid.no_pulse", pulses, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            bit          fast;
            logic [31:0] corner [4];
            corner[0] = 32'd0; corner[1] = 32'd1;
            corner[2] = 32'hFFFFFFFF; corner[3] = 32'h80000000;
            f3   = 3'($urandom_range(0, 7));
            a    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            fast = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom_range(0, 31)), fast,
                   ref_model(f3, a, b), ref_lat(f3, a, b, fast));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/exu_muldiv.md
# exu_muldiv

Iterative RV32M multiply/divide execute unit. Sits beside the base execute stage and takes the ID/EX operands of `INS_TYPE_R_M` instructions with funct7 = 0000001. It stalls the pipeline through the control unit until its result is ready, then drives a one-cycle register write-back. Operand width and multiplier mode are parametrised.

## Interface
- `XLEN`, 32: operand and result width; must be ≥ 8.
- `REG_AW`, 5: register address width.
- `FAST_MUL`, 0: multiplier mode.
  - 0: shift-add multiply, one bit per cycle.
  - 1: single-cycle combinational product.
- `clk` in 1: clock; all state is updated on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `idex2mdu_valid_i` in 1: an M-extension operation is present in EX.
- `idex2mdu_funct3_i` in 3: operation select, MUL…REMU = 000…111.
- `idex2mdu_source1_i` in XLEN: rs1 value.
- `idex2mdu_source2_i` in XLEN: rs2 value.
- `idex2mdu_rd_addr_i` in REG_AW: destination register.
- `cu2mdu_flush_i` in 1: kill the EX instruction.
- `mdu2cu_stall_o` out 1: hold IF/ID/EX.
- `mdu2regs_wb_en_o` out 1: write-back pulse.
- `mdu2regs_rd_addr_o` out REG_AW: write-back address; registered.
- `mdu2regs_rd_data_o` out XLEN: write-back data; registered.
- `mdu_busy_o` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Counter width is clog2(XLEN)+1.
- **Accept (IDLE):** occurs when `valid_i` is high and `flush` is low.
  - Latch funct3 and rd.
  - Latch operand magnitudes: the absolute value for signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both). Record the result sign.
  - Counter is loaded with XLEN.
- **Next state after accept:**
  - Divisor = 0 → DONE. Quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones, DIV/REM) → DONE. Quotient = rs1; remainder = 0.
  - Multiply with FAST_MUL = 1 → DONE with the full 2·XLEN product.
  - Otherwise → MUL or DIV.
- **MUL state:** one shift-add step per cycle into a 2·XLEN accumulator. Counter decrements each step; at 1 → DONE.
- **DIV state:** one restoring step per cycle: shift in the next dividend bit, subtract the divisor if no borrow, set the quotient bit. Counter decrements each step; at 1 → DONE.
- **Sign fix-up, applied on entry to DONE:**
  - Product is negated (2·XLEN wide) if the recorded sign is negative.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Special-case results bypass fix-up.
- **Result select:**
  - MUL: low XLEN bits.
  - MULH / MULHSU / MULHU: high XLEN bits.
  - DIV / DIVU: quotient.
  - REM / REMU: remainder.
- **DONE state:** `wb_en_o` = 1 for exactly this cycle; rd and data registers update at entry to DONE. rd = 0 still pulses; the regfile ignores x0. Unconditional return to IDLE. `valid_i` is ignored in DONE, because the same instruction is still presented.
- **Flush:** `flush` high in any state → IDLE next edge, no write-back pulse. In DONE, flush forces `wb_en_o` low combinationally. In IDLE, flush blocks acceptance.
- **Stall:** `stall_o` = (IDLE & `valid_i` & ~`flush`) | MUL | DIV. It is low in DONE so the pipeline advances on that edge.
- Operand inputs are not re-sampled after accept.

## Timing
- **Reset:** state IDLE, counter 0, accumulators 0. All outputs read 0 (`stall`, `wb_en`, `rd_addr`, `rd_data`, `busy`).
- Reset is asynchronous mid-operation: outputs clear immediately, with no pulse after release.
- With accept at cycle T, DONE (`wb_en_o` high) occurs at:
  - iterative MUL/DIV: T+XLEN+1;
  - FAST_MUL multiply or special-case division: T+1.
- `stall_o` is high during cycles T … DONE-1.
- Back-to-back operations: the next accept is no earlier than DONE+1, i.e. an issue interval of XLEN+2 cycles iterative, 2 cycles fast.
- `rd_addr_o` / `rd_data_o` hold their values after DONE until the next DONE.

## Test plan
- **MUL:** XLEN=32, FAST_MUL=0, MUL 7 × 0xFFFFFFFD.
  - `stall` high T..T+32.
  - `wb_en` single pulse at T+33, data 0xFFFFFFEB.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Division:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Each at T+33.
- **Special cases:** each result at T+1, `stall` high only at T.
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Flush:** flush at T+10 during DIV.
  - No `wb_en` pulse; IDLE at T+11.
  - New `valid` at T+11 is accepted, with correct result at T+44.
- **Reset and fast mode:**
  - `rst` asserted mid-MUL: all outputs 0 in the same cycle, no pulse afterward.
  - FAST_MUL=1, MUL 0x10000 × 0x10000 → 0, with MULHU → 1, each at T+1.
